pipeline_stall_controller: RTL

Central stall/flush sequencer for the 5-stage MIPS pipeline. Combines the load-use hazard signal, taken-branch redirect, multi-cycle multiply/divide occupancy and data-memory wait into one coherent set of per-stage write-enable, bubble and flush controls, so no two sources fight over a pipeline register. Sits beside the hazard detection unit; its outputs drive the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB register enables.

---
 rtl/pipeline_pkg.sv | 37 +++
 rtl/sat_counter.sv | 26 ++
 rtl/pipeline_stall_controller.sv | 114 +++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the 5-stage pipeline control slice: sequencer state,
// per-stage control bundle and the canned control patterns.
package pipeline_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } stall_state_t;

    localparam int DEFAULT_MDU_LATENCY = 4;
    localparam int MDU_CNT_W           = 4;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_we;
        logic id_ex_bubble;
        logic ex_mem_we;
        logic ex_mem_bubble;
        logic mem_wb_we;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_HOLD = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam stage_ctrl_t CTRL_RUN  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam stage_ctrl_t CTRL_MDU  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam stage_ctrl_t CTRL_LU   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // Normal flow with the wrong-path IF instruction squashed.
    function automatic stage_ctrl_t ctrl_branch();
        stage_ctrl_t c;
        c             = CTRL_RUN;
        c.if_id_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count enabled cycles, sticking at all-ones.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count_r <= '0;
        end else if (en && (count_r != {W{1'b1}})) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer: merges memory wait, MDU occupancy, load-use
// and branch redirect into one consistent set of pipeline register controls.
module pipeline_stall_controller
    import pipeline_pkg::*;
#(
    parameter int MDU_LATENCY = DEFAULT_MDU_LATENCY,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_use_hazard,
    input  logic             branch_taken,
    input  logic             mdu_start,
    input  logic             mem_wait,
    output logic             PC_write_en,
    output logic             IF_ID_write_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_write_en,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_write_en,
    output logic             EX_MEM_bubble,
    output logic             MEM_WB_write_en,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [CNT_W-1:0] stall_cycles
);

    // The issue cycle counts as one MDU cycle, and the zero count is another.
    localparam logic [MDU_CNT_W-1:0] MDU_LOAD = MDU_CNT_W'(MDU_LATENCY - 2);

    stall_state_t         state_r;
    logic [MDU_CNT_W-1:0] mdu_cnt_r;
    logic                 frozen_s;
    logic                 mdu_busy_s;
    logic                 mdu_done_s;
    stage_ctrl_t          ctrl_s;

    // MDU occupancy sequencer; everything holds while memory is waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= RUN;
            mdu_cnt_r <= {MDU_CNT_W{1'b0}};
        end else if (!mem_wait) begin
            case (state_r)
                RUN: begin
                    if (mdu_start) begin
                        mdu_cnt_r <= MDU_LOAD;
                        state_r   <= MDU_WAIT;
                    end else begin
                        state_r   <= RUN;
                    end
                end
                MDU_WAIT: begin
                    if (mdu_cnt_r == {MDU_CNT_W{1'b0}}) begin
                        state_r   <= RUN;
                    end else begin
                        mdu_cnt_r <= mdu_cnt_r - {{(MDU_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r   <= RUN;
                    mdu_cnt_r <= {MDU_CNT_W{1'b0}};
                end
            endcase
        end else begin
            state_r   <= state_r;
            mdu_cnt_r <= mdu_cnt_r;
        end
    end

    // Priority resolution of stall sources into stage controls.
    always_comb begin
        frozen_s   = ((state_r == RUN) && mdu_start) || (state_r == MDU_WAIT);
        ctrl_s     = CTRL_HOLD;
        mdu_busy_s = 1'b0;
        mdu_done_s = 1'b0;
        if (!reset_n) begin
            ctrl_s = CTRL_HOLD;
        end else begin
            mdu_busy_s = frozen_s;
            mdu_done_s = (state_r == MDU_WAIT) && (mdu_cnt_r == {MDU_CNT_W{1'b0}}) && !mem_wait;
            if (mem_wait) begin
                ctrl_s = CTRL_HOLD;
            end else if (frozen_s) begin
                ctrl_s = CTRL_MDU;
            end else if (load_use_hazard) begin
                ctrl_s = CTRL_LU;
            end else if (branch_taken) begin
                ctrl_s = ctrl_branch();
            end else begin
                ctrl_s = CTRL_RUN;
            end
        end
    end

    assign PC_write_en     = ctrl_s.pc_we;
    assign IF_ID_write_en  = ctrl_s.if_id_we;
    assign IF_ID_flush     = ctrl_s.if_id_flush;
    assign ID_EX_write_en  = ctrl_s.id_ex_we;
    assign ID_EX_bubble    = ctrl_s.id_ex_bubble;
    assign EX_MEM_write_en = ctrl_s.ex_mem_we;
    assign EX_MEM_bubble   = ctrl_s.ex_mem_bubble;
    assign MEM_WB_write_en = ctrl_s.mem_wb_we;
    assign mdu_busy        = mdu_busy_s;
    assign mdu_done        = mdu_done_s;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .clear_n (reset_n),
        .en      (~ctrl_s.pc_we),
        .count   (stall_cycles)
    );

endmodule
